// File: rtl/aes_512_seq.sv
// aes_512_seq: sequences one 512-bit stream word through a 128-bit AES-128 core as four blocks
// Optional feature: define AES512_TIMEOUT_EN to abort a word when core_done does not arrive
//   within DONE_TIMEOUT WAIT cycles; the abort sets the sticky err flag.
// Ports:
//   clk, rst           clock; synchronous active-low reset (shared with the core)
//   in_valid/in_ready  input handshake; in_ready is high only in IDLE
//   in_key, in_data    128-bit key and 512-bit plaintext (block 0 = [511:384])
//   out_valid/out_ready, out_data   output handshake and 512-bit ciphertext
//   core_ld, core_key, core_text_in outgoing core load pulse, key and block
//   core_done, core_text_out        core completion pulse and ciphertext block
//   busy, err          busy outside IDLE; sticky timeout flag (0 without the feature)
module aes_512_seq
`ifdef AES512_TIMEOUT_EN
#(
    parameter int DONE_TIMEOUT = 16
)
`endif
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [511:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out,
    output logic         busy,
    output logic         err
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_OUT} state_t;
    state_t       r_state;
    logic [1:0]   r_idx;
    logic [511:0] r_data;
    logic [511:0] r_res;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_core_ld;
    logic [127:0] r_core_key;
    logic [127:0] r_core_text_in;
    logic         r_busy;
    logic [1:0]   w_idx_nx;
`ifdef AES512_TIMEOUT_EN
    localparam int CW = $clog2(DONE_TIMEOUT);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif
    assign w_idx_nx     = r_idx + 2'd1;
    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_res;
    assign core_ld      = r_core_ld;
    assign core_key     = r_core_key;
    assign core_text_in = r_core_text_in;
    assign busy         = r_busy;
    // Block i sits at bit offset (3-i)*128, i.e. {~i, 7'd0} for a 2-bit index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_idx          <= 2'd0;
            r_data         <= '0;
            r_res          <= '0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_core_ld      <= 1'b0;
            r_core_key     <= '0;
            r_core_text_in <= '0;
            r_busy         <= 1'b0;
`ifdef AES512_TIMEOUT_EN
            r_cnt          <= '0;
            r_err          <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_data         <= in_data;
                    r_core_key     <= in_key;
                    r_core_text_in <= in_data[511:384];
                    r_idx          <= 2'd0;
                    r_core_ld      <= 1'b1;
                    r_in_ready     <= 1'b0;
                    r_busy         <= 1'b1;
                    r_state        <= S_LOAD;
`ifdef AES512_TIMEOUT_EN
                    r_err          <= 1'b0;
`endif
                end
                S_LOAD: begin
                    r_core_ld <= 1'b0;
                    r_state   <= S_WAIT;
`ifdef AES512_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_res[{~r_idx, 7'd0} +: 128] <= core_text_out;
                        if (r_idx == 2'd3) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_idx          <= w_idx_nx;
                            r_core_text_in <= r_data[{~w_idx_nx, 7'd0} +: 128];
                            r_core_ld      <= 1'b1;
                            r_state        <= S_LOAD;
                        end
                    end
`ifdef AES512_TIMEOUT_EN
                    else if (r_cnt == CW'(DONE_TIMEOUT - 1)) begin
                        r_err      <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
`endif
                end
                S_OUT: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_512_seq.sv
// tb_aes_512_seq: self-checking bench for aes_512_seq with a behavioural 12-cycle core model
module tb_aes_512_seq;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic         core_done = 1'b0, force_low = 1'b0, spur = 1'b0;
    logic         in_ready, out_valid, core_ld, busy, err;
    logic [127:0] in_key = '0, core_key, core_text_in, core_text_out = '0, m_txt = '0, m_key = '0;
    logic [511:0] in_data = '0, out_data;
    int           cyc = 0, acc_cyc = 0, hs_cnt = 0, errors = 0, checks = 0, words = 0, cnt = 0;
    bit           pend = 1'b0;
    int           ld_q[$];
    logic [511:0] exp_q[$];

    typedef struct {
        logic [127:0] key;
        logic [511:0] data;
        logic [511:0] exp;
        int           stall;
        bit           toggle;
    } vec_t;
    vec_t tv[4];

    aes_512_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
        .core_done(core_done), .core_text_out(core_text_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cipher: the FIPS-197 pair maps to its real ciphertext, anything else to a keyed scramble.
    function automatic logic [127:0] f(input logic [127:0] b, input logic [127:0] k);
        if (b == PT && k == K0) return CT;
        return {b[63:0], b[127:64]} ^ k ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [511:0] expw(input logic [511:0] d, input logic [127:0] k);
        logic [511:0] r;
        for (int b = 0; b < 4; b++) r[(3-b)*128 +: 128] = f(d[(3-b)*128 +: 128], k);
        return r;
    endfunction

    // Core model: done exactly 12 cycles after the load, garbage on the data bus otherwise.
    always @(posedge clk) begin
        if (!rst) begin
            pend      <= 1'b0;
            cnt       <= 0;
            core_done <= 1'b0;
        end else begin
            core_done     <= 1'b0;
            core_text_out <= {$urandom, $urandom, $urandom, $urandom};
            if (core_ld) begin
                pend  <= 1'b1;
                cnt   <= 11;
                m_txt <= core_text_in;
                m_key <= core_key;
            end else if (pend) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    pend <= 1'b0;
                    if (!force_low) begin
                        core_done     <= 1'b1;
                        core_text_out <= f(m_txt, m_key);
                    end
                end
            end
            if (spur) core_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst && in_valid && in_ready) begin
            acc_cyc = cyc;
            ld_q.delete();
        end
        if (core_ld) ld_q.push_back(cyc - acc_cyc);
        if (rst && out_valid && out_ready) hs_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 100000", cyc);
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", n, got, want);
        end
    endtask

    task automatic run_word(input vec_t v);
        int t;
        logic [511:0] held;
        in_valid = 1'b1;
        in_data  = v.data;
        in_key   = v.key;
        exp_q.push_back(v.exp);
        words++;
        step;
        in_valid = 1'b0;
        chk("err_clear", err, 0);
        chk("busy_after_accept", busy, 1);
        t = 0;
        while (!out_valid && t < 200) begin
            if (v.toggle) begin
                in_valid = ~in_valid;
                for (int j = 0; j < 16; j++) in_data[j*32 +: 32] = $urandom;
            end
            step;
            t++;
        end
        in_valid = 1'b0;
        chk("out_valid_seen", out_valid, 1);
        chk("latency", cyc - acc_cyc, 53);
        chk("ld_count", ld_q.size(), 4);
        foreach (ld_q[i]) chk("ld_cycle", ld_q[i], 1 + 13 * i);
        chk("core_key_held", core_key, v.key);
        held = out_data;
        for (int i = 0; i < v.stall; i++) begin
            spur = (i == 5);
            step;
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, held);
            chk("stall_in_ready", in_ready, 0);
        end
        spur = 1'b0;
        out_ready = 1'b1;
        chk("sb_nonempty", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
        step;
        out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        logic [511:0] d;
        tv[0] = '{K0, {4{PT}}, {4{CT}}, 0, 1'b0};
        d = {PT, 128'h0123456789abcdeffedcba9876543210, 128'hdeadbeefcafef00d0badc0de12345678, 128'h0};
        tv[1] = '{K0, d, expw(d, K0), 20, 1'b0};
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
        tv[2].key    = {$urandom, $urandom, $urandom, $urandom};
        tv[2].data   = d;
        tv[2].exp    = expw(d, tv[2].key);
        tv[2].stall  = 3;
        tv[2].toggle = 1'b1;
        d = '0;
        tv[3] = '{'1, d, expw(d, '1), 0, 1'b0};

        repeat (3) step;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_core_ld", core_ld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_text_in", core_text_in, 0);
        rst = 1'b1;
        step;

        for (int i = 0; i < 3; i++) run_word(tv[i]);

        // Reset mid-word: rst low during cycle 30 after the accept.
        in_valid = 1'b1;
        in_data  = tv[2].data;
        in_key   = tv[2].key;
        step;
        in_valid = 1'b0;
        for (int t = 0; t < 100 && cyc - acc_cyc < 30; t++) step;
        rst = 1'b0;
        step;
        rst = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_core_ld", core_ld, 0);
        run_word(tv[3]);

`ifdef AES512_TIMEOUT_EN
        force_low = 1'b1;
        in_valid  = 1'b1;
        in_data   = tv[1].data;
        in_key    = tv[1].key;
        step;
        in_valid = 1'b0;
        for (int t = 0; t < 100 && cyc - acc_cyc < 17; t++) step;
        chk("to_err_c17", err, 0);
        chk("to_busy_c17", busy, 1);
        step;
        chk("to_err_c18", err, 1);
        chk("to_in_ready_c18", in_ready, 1);
        chk("to_busy_c18", busy, 0);
        begin
            int ov = 0;
            for (int t = 0; t < 40; t++) begin
                step;
                if (out_valid) ov++;
            end
            chk("to_no_out_valid", ov, 0);
        end
        chk("to_err_sticky", err, 1);
        force_low = 1'b0;
        run_word(tv[0]);
`else
        chk("err_tied_low", err, 0);
`endif

        chk("sb_empty", exp_q.size(), 0);
        chk("handshakes", hs_cnt, words);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
